// File: rtl/combo_pkg.sv
// rtl/combo_pkg.sv - shared state encoding and default parameters for combo_entry
package combo_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        FULL    = 2'd2
    } combo_state_t;

    localparam int unsigned DIGIT_W_DEF        = 4;
    localparam int unsigned NUM_DIGITS_DEF     = 4;
    localparam int unsigned DB_CYCLES_DEF      = 65536;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 2**26;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-flop synchronizer plus saturating stability-counter debouncer
module btn_debounce
    import combo_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic clr,
    input  logic btn,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] cnt;
    logic             settle;

    assign settle        = (sync2 != level) && (cnt == CNT_LAST);
    assign press_pulse   = settle && sync2;
    assign release_pulse = settle && !sync2;

    // Accepted level comes out of reset as "pressed" so a button held through
    // clr must first debounce a release before any press can be accepted.
    always_ff @(posedge clk) begin
        if (clr) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b1;
            cnt   <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (settle) begin
                level <= sync2;
                cnt   <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/combo_entry.sv
// rtl/combo_entry.sv - digit-entry FSM with one-hot write strobes; COMBO_ENTRY_TIMEOUT_EN adds idle abort
module combo_entry
    import combo_pkg::*;
#(
    parameter int unsigned DIGIT_W        = DIGIT_W_DEF,
    parameter int unsigned NUM_DIGITS     = NUM_DIGITS_DEF,
    parameter int unsigned DB_CYCLES      = DB_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                               clk,
    input  logic                               clr,
    input  logic                               btn_enter,
    input  logic [DIGIT_W-1:0]                 sw,
    output logic [NUM_DIGITS-1:0]              wr_en,
    output logic [DIGIT_W-1:0]                 wr_data,
    output logic [$clog2(NUM_DIGITS+1)-1:0]    digit_idx,
    output logic                               code_done,
    output logic                               timeout
);

    localparam int IDX_W = $clog2(NUM_DIGITS + 1);
    localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(NUM_DIGITS);

    if (DB_CYCLES == 0 || TIMEOUT_CYCLES == 0) begin : g_bad_param
        $error("combo_entry: DB_CYCLES and TIMEOUT_CYCLES must be nonzero");
    end

    combo_state_t     state;
    combo_state_t     state_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic             press_pulse;
    logic             release_pulse;
    logic             idle_abort;

    btn_debounce #(
        .DB_CYCLES(DB_CYCLES)
    ) u_debounce (
        .clk          (clk),
        .clr          (clr),
        .btn          (btn_enter),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

`ifdef COMBO_ENTRY_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] idle_cnt;
    logic            idle_run;

    assign idle_run   = (state == IDLE) && (digit_idx != '0) && (digit_idx < IDX_FULL);
    assign idle_abort = idle_run && (idle_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (clr || !idle_run || idle_abort || press_pulse) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign idle_abort = 1'b0;
`endif

    assign timeout   = idle_abort && !clr;
    assign code_done = (state == FULL);

    // Abort wins over a press landing in the same cycle; clr suppresses any strobe.
    always_comb begin
        state_nxt = state;
        idx_nxt   = digit_idx;
        wr_en     = '0;
        wr_data   = '0;
        case (state)
            IDLE: begin
                if (idle_abort) begin
                    idx_nxt = '0;
                end else if (press_pulse && (digit_idx < IDX_FULL)) begin
                    wr_en     = NUM_DIGITS'(1) << digit_idx;
                    wr_data   = sw;
                    idx_nxt   = digit_idx + 1'b1;
                    state_nxt = PRESSED;
                end
            end
            PRESSED: begin
                if (release_pulse) begin
                    state_nxt = (digit_idx == IDX_FULL) ? FULL : IDLE;
                end
            end
            FULL: begin
                state_nxt = FULL;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (clr) begin
            wr_en   = '0;
            wr_data = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= IDLE;
            digit_idx <= '0;
        end else begin
            state     <= state_nxt;
            digit_idx <= idx_nxt;
        end
    end

endmodule

// File: tb/tb_combo_entry.sv
// tb/tb_combo_entry.sv - randomized self-checking bench for combo_entry against a behavioural model
module tb_combo_entry;

    localparam int DW = 4;
    localparam int ND = 4;
    localparam int DB = 4;
    localparam int TO = 20;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       btn_enter = 1'b0;
    logic [3:0] sw = 4'd0;
    logic [3:0] wr_en;
    logic [3:0] wr_data;
    logic [2:0] digit_idx;
    logic       code_done;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    combo_entry #(
        .DIGIT_W       (DW),
        .NUM_DIGITS    (ND),
        .DB_CYCLES     (DB),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .btn_enter(btn_enter),
        .sw       (sw),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .digit_idx(digit_idx),
        .code_done(code_done),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: synced button = raw button two cycles back; a level is
    // accepted once it has persisted DB cycles and differs from the accepted one.
    bit         m_hist[$];
    bit         m_prev  = 1'b0;
    int         m_run   = 0;
    bit         m_level = 1'b1;
    int         m_idx   = 0;
    bit         m_full  = 1'b0;
    bit         m_hold  = 1'b0;
    int         m_idle  = 0;
    logic [3:0] log_en[$];
    logic [3:0] log_data[$];
    int         to_count = 0;

    task automatic model_reset();
        m_hist.delete();
        m_prev  = 1'b0;
        m_run   = 0;
        m_level = 1'b1;
        m_idx   = 0;
        m_full  = 1'b0;
        m_hold  = 1'b0;
        m_idle  = 0;
    endtask

    task automatic step();
        bit         sync;
        bit         acc;
        bit         press;
        bit         rel;
        bit         counting;
        bit         exp_to;
        logic [3:0] exp_en;
        logic [3:0] exp_d;
        int         n;
        n    = m_hist.size();
        sync = (n >= 2) ? m_hist[n-2] : 1'b0;
        if (sync == m_prev) m_run++;
        else m_run = 1;
        m_prev   = sync;
        acc      = (sync != m_level) && (m_run == DB);
        press    = acc && sync;
        rel      = acc && !sync;
        counting = !m_full && !m_hold && (m_idx > 0) && (m_idx < ND);
        exp_to   = 1'b0;
`ifdef COMBO_ENTRY_TIMEOUT_EN
        if (counting && (m_idle + 1 == TO) && !clr) exp_to = 1'b1;
`endif
        exp_en = 4'd0;
        exp_d  = 4'd0;
        if (!clr && !exp_to && press && !m_hold && !m_full) begin
            exp_en = 4'(1 << m_idx);
            exp_d  = sw;
        end
        chk("wr_en", int'(wr_en), int'(exp_en));
        chk("wr_data", int'(wr_data), int'(exp_d));
        chk("digit_idx", int'(digit_idx), m_idx);
        chk("code_done", int'(code_done), int'(m_full));
        chk("timeout", int'(timeout), int'(exp_to));
        if (wr_en != 4'd0) begin
            log_en.push_back(wr_en);
            log_data.push_back(wr_data);
        end
        if (timeout) to_count++;
        if (clr) begin
            model_reset();
        end else begin
            m_hist.push_back(btn_enter);
            if (exp_to) begin
                m_idx  = 0;
                m_idle = 0;
            end else if (counting) begin
                m_idle++;
            end else begin
                m_idle = 0;
            end
            if (exp_en != 4'd0) begin
                m_idx++;
                m_hold = 1'b1;
                m_idle = 0;
            end
            if (acc) m_level = sync;
            if (rel && m_hold) begin
                m_hold = 1'b0;
                if (m_idx == ND) m_full = 1'b1;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            step();
        end
    end

    task automatic cyc(input bit b, input logic [3:0] s, input bit c);
        @(negedge clk);
        btn_enter = b;
        sw        = s;
        clr       = c;
    endtask

    task automatic hold(input bit b, input int n, input logic [3:0] s);
        for (int i = 0; i < n; i++) cyc(b, s, 1'b0);
    endtask

    task automatic do_reset();
        cyc(1'b0, 4'd0, 1'b1);
        hold(1'b0, 8, 4'd0);
        #3;
        log_en.delete();
        log_data.delete();
        to_count = 0;
    endtask

    task automatic press_digit(input logic [3:0] s);
        hold(1'b1, 8, s);
        hold(1'b0, 8, s);
    endtask

    initial begin
        logic [3:0] exp_en_tab[4];
        logic [3:0] exp_dat_tab[4];
        exp_en_tab  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        exp_dat_tab = '{4'd3, 4'd1, 4'd4, 4'd1};

        // Reset state and single clean entry
        do_reset();
        chk("rst_idx", int'(digit_idx), 0);
        chk("rst_done", int'(code_done), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        press_digit(4'h7);
        #3;
        chk("one_cnt", log_en.size(), 1);
        chk("one_en", int'(log_en[0]), 1);
        chk("one_data", int'(log_data[0]), 7);
        chk("one_idx", int'(digit_idx), 1);

        // Full four-digit code, then an ignored fifth press
        do_reset();
        press_digit(4'd3);
        press_digit(4'd1);
        press_digit(4'd4);
        press_digit(4'd1);
        #3;
        chk("four_cnt", log_en.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("four_en%0d", i), int'(log_en[i]), int'(exp_en_tab[i]));
            chk($sformatf("four_data%0d", i), int'(log_data[i]), int'(exp_dat_tab[i]));
        end
        chk("four_done", int'(code_done), 1);
        chk("four_idx", int'(digit_idx), 4);
        press_digit(4'd9);
        #3;
        chk("fifth_cnt", log_en.size(), 4);
        chk("fifth_done", int'(code_done), 1);

        // Bounce then long hold
        do_reset();
        cyc(1'b1, 4'd5, 1'b0);
        cyc(1'b0, 4'd5, 1'b0);
        cyc(1'b1, 4'd5, 1'b0);
        cyc(1'b1, 4'd5, 1'b0);
        cyc(1'b0, 4'd5, 1'b0);
        cyc(1'b1, 4'd5, 1'b0);
        hold(1'b1, 10, 4'd5);
        #3;
        chk("bounce_cnt", log_en.size(), 1);
        hold(1'b1, 100, 4'd5);
        #3;
        chk("hold_cnt", log_en.size(), 1);
        hold(1'b0, 8, 4'd0);

        // clr while the second digit is held down
        do_reset();
        press_digit(4'd2);
        hold(1'b1, 8, 4'd5);
        cyc(1'b1, 4'd5, 1'b1);
        cyc(1'b1, 4'd5, 1'b0);
        #3;
        chk("clr_idx", int'(digit_idx), 0);
        chk("clr_done", int'(code_done), 0);
        hold(1'b1, 30, 4'd5);
        #3;
        chk("clr_held_cnt", log_en.size(), 2);
        hold(1'b0, 8, 4'd0);
        press_digit(4'hA);
        #3;
        chk("clr_re_cnt", log_en.size(), 3);
        chk("clr_re_en", int'(log_en[2]), 1);
        chk("clr_re_data", int'(log_data[2]), 10);

        // clr lands on the very cycle the press is accepted
        do_reset();
        hold(1'b1, 5, 4'd6);
        cyc(1'b1, 4'd6, 1'b1);
        hold(1'b1, 20, 4'd6);
        #3;
        chk("clr_same_cnt", log_en.size(), 0);
        chk("clr_same_idx", int'(digit_idx), 0);
        hold(1'b0, 8, 4'd0);
        press_digit(4'd6);
        #3;
        chk("clr_same_re_cnt", log_en.size(), 1);

        // Idle after one digit
        do_reset();
        press_digit(4'd7);
        hold(1'b0, 40, 4'd0);
        #3;
`ifdef COMBO_ENTRY_TIMEOUT_EN
        chk("idle_to_cnt", to_count, 1);
        chk("idle_idx", int'(digit_idx), 0);
`else
        chk("idle_to_cnt", to_count, 0);
        chk("idle_idx", int'(digit_idx), 1);
`endif

        // Randomized button activity with occasional clr
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int k = 0; k < 40; k++) begin
                bit b;
                int n;
                b = 1'($urandom_range(0, 1));
                n = $urandom_range(1, 9);
                for (int j = 0; j < n; j++) cyc(b, 4'($urandom), 1'b0);
                if ($urandom_range(0, 19) == 0) cyc(b, 4'($urandom), 1'b1);
            end
        end

        hold(1'b0, 4, 4'd0);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
